// File: rtl/riscv_alu_seq.sv
// Multi-cycle integer ALU with valid/ready handshakes on both sides.
// Logic, arithmetic and compare ops finish in one edge; shifts iterate SHIFT_STEP bits per cycle.
module riscv_alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [3:0]       shiftOp_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   remain_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             accept;
  logic             isShift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] bOperand;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] aluResult_d;
  logic             aluCout_d;
  logic             aluOvf_d;
  logic [SHW-1:0]   stepN;
  logic [WIDTH-1:0] shifted_d;
  logic             lastStep;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  assign isShift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign shamt   = b[SHW-1:0];

  // One shared adder: SUB is a + ~b + 1, so cout doubles as "no borrow".
  always_comb begin
    bOperand    = (op == OP_SUB) ? ~b : b;
    sum         = {1'b0, a} + {1'b0, bOperand} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    aluResult_d = '0;
    aluCout_d   = 1'b0;
    aluOvf_d    = 1'b0;
    case (op)
      OP_AND:  aluResult_d = a & b;
      OP_OR:   aluResult_d = a | b;
      OP_XOR:  aluResult_d = a ^ b;
      OP_ADD: begin
        aluResult_d = sum[WIDTH-1:0];
        aluCout_d   = sum[WIDTH];
        aluOvf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluResult_d = sum[WIDTH-1:0];
        aluCout_d   = sum[WIDTH];
        aluOvf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  aluResult_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: aluResult_d = {{(WIDTH-1){1'b0}}, (a < b)};
      default: aluResult_d = '0;
    endcase
  end

  // Remaining count is always below WIDTH, so the final partial step never exceeds it.
  always_comb begin
    if ({1'b0, remain_q} < STEP_W) stepN = remain_q;
    else                           stepN = STEP_W[SHW-1:0];
    case (shiftOp_q)
      OP_SLL:  shifted_d = work_q << stepN;
      OP_SRL:  shifted_d = work_q >> stepN;
      default: shifted_d = $signed(work_q) >>> stepN;
    endcase
    lastStep = (remain_q == stepN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shiftOp_q <= '0;
      work_q    <= '0;
      remain_q  <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else if (accept) begin
      if (isShift) begin
        shiftOp_q <= op;
        work_q    <= a;
        remain_q  <= shamt;
        if (shamt == '0) begin
          state_q  <= DONE;
          result_q <= a;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
          zero_q   <= (a == '0);
        end else begin
          state_q <= SHIFT;
        end
      end else begin
        state_q  <= DONE;
        result_q <= aluResult_d;
        cout_q   <= aluCout_d;
        ovf_q    <= aluOvf_d;
        zero_q   <= (aluResult_d == '0);
      end
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        SHIFT: begin
          work_q   <= shifted_d;
          remain_q <= remain_q - stepN;
          if (lastStep) begin
            state_q  <= DONE;
            result_q <= shifted_d;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= (shifted_d == '0);
          end
        end
        DONE:    if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Self-checking bench for riscv_alu_seq: directed vector table, randomized ops against
// an arithmetic reference model, and hand sequences for reset, backpressure and STEP=4.
module tb_riscv_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetN;
  logic         inValid[2];
  logic         inReady[2];
  logic [3:0]   opIn[2];
  logic [W-1:0] aIn[2];
  logic [W-1:0] bIn[2];
  logic         outValid[2];
  logic         outReady[2];
  logic [W-1:0] res[2];
  logic         coutO[2];
  logic         ovfO[2];
  logic         zeroO[2];

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  riscv_alu_seq #(.WIDTH(W), .SHIFT_STEP(1)) dut0 (
    .clk(clk), .reset_n(resetN), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .op(opIn[0]), .a(aIn[0]), .b(bIn[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .result(res[0]), .cout(coutO[0]), .ovf(ovfO[0]), .zero(zeroO[0])
  );

  riscv_alu_seq #(.WIDTH(W), .SHIFT_STEP(4)) dut1 (
    .clk(clk), .reset_n(resetN), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .op(opIn[1]), .a(aIn[1]), .b(bIn[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .result(res[1]), .cout(coutO[1]), .ovf(ovfO[1]), .zero(zeroO[1])
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on the operands.
  function automatic void refAlu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic o, output logic z);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    int     sh = int'(b[4:0]);
    logic [W:0] wide;
    r = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[W-1:0]; c = wide[W];
        s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        r = a - b; c = (a >= b);
        s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = $signed(a) >>> sh;
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [W-1:0] b, input int step);
    int sh = int'(b[4:0]);
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && sh > 0) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  // Issue one op, wait for acceptance, then count edges until out_valid (out_ready held high).
  task automatic applyStimulus(input int sel, input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, output logic [W-1:0] r, output logic c,
                               output logic o, output logic z, output int lat);
    int guard = 0;
    @(negedge clk);
    inValid[sel] = 1'b1; opIn[sel] = op; aIn[sel] = a; bIn[sel] = b;
    while (!inReady[sel] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("acceptTimeout", 64'(inReady[sel]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    inValid[sel] = 1'b0;
    lat = 1;
    while (!outValid[sel] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = res[sel]; c = coutO[sel]; o = ovfO[sel]; z = zeroO[sel];
  endtask

  task automatic compareAll(input string tag, input logic [W-1:0] r, input logic c, input logic o,
                            input logic z, input int lat, input logic [W-1:0] er, input logic ec,
                            input logic eo, input logic ez, input int elat);
    checkOutput({tag, ".result"}, 64'(r), 64'(er));
    checkOutput({tag, ".cout"}, 64'(c), 64'(ec));
    checkOutput({tag, ".ovf"}, 64'(o), 64'(eo));
    checkOutput({tag, ".zero"}, 64'(z), 64'(ez));
    checkOutput({tag, ".latency"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] r, er, ra, rb;
    logic         c, o, z, ec, eo, ez;
    logic [3:0]   rop;
    int           lat, stale;
    logic [W-1:0] seqExp[3];
    logic [3:0]   seqOp[3];
    logic [W-1:0] seqA[3];
    logic [W-1:0] seqB[3];

    vecs.push_back('{4'd2, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1, 1, "addWrap"});
    vecs.push_back('{4'd2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1, "addOvf"});
    vecs.push_back('{4'd3, 32'h3, 32'h5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1, "subBorrow"});
    vecs.push_back('{4'd3, 32'h5, 32'h3, 32'h2, 1'b1, 1'b0, 1'b0, 1, "subNoBorrow"});
    vecs.push_back('{4'd3, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1, "subOvf"});
    vecs.push_back('{4'd3, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b1, 1, "subEqual"});
    vecs.push_back('{4'd5, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1, "slt"});
    vecs.push_back('{4'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1, "sltu"});
    vecs.push_back('{4'd9, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5, "sra4"});
    vecs.push_back('{4'd8, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1, "srl0"});
    vecs.push_back('{4'd7, 32'h1, 32'hFFFFFFE3, 32'h8, 1'b0, 1'b0, 1'b0, 4, "sllMaskedShamt"});
    vecs.push_back('{4'd8, 32'h80000000, 32'd31, 32'h1, 1'b0, 1'b0, 1'b0, 32, "srl31"});
    vecs.push_back('{4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1, "and"});
    vecs.push_back('{4'd1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0, 1, "or"});
    vecs.push_back('{4'd4, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1'b0, 1, "xor"});
    vecs.push_back('{4'd15, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, 1'b1, 1, "reserved15"});

    for (int i = 0; i < 2; i++) begin
      inValid[i] = 1'b0; opIn[i] = '0; aIn[i] = '0; bIn[i] = '0; outReady[i] = 1'b1;
    end
    resetN = 1'b0;

    #12;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset.outValid", 64'(outValid[i]), 64'd0);
      checkOutput("reset.result", 64'(res[i]), 64'd0);
      checkOutput("reset.zero", 64'(zeroO[i]), 64'd1);
      checkOutput("reset.cout", 64'(coutO[i]), 64'd0);
      checkOutput("reset.ovf", 64'(ovfO[i]), 64'd0);
    end
    @(negedge clk);
    resetN = 1'b1;
    #1;
    checkOutput("reset.inReady0", 64'(inReady[0]), 64'd1);
    checkOutput("reset.inReady1", 64'(inReady[1]), 64'd1);

    foreach (vecs[k]) begin
      applyStimulus(0, vecs[k].op, vecs[k].a, vecs[k].b, r, c, o, z, lat);
      compareAll(vecs[k].name, r, c, o, z, lat, vecs[k].r, vecs[k].c, vecs[k].o, vecs[k].z, vecs[k].lat);
    end

    for (int i = 0; i < 160; i++) begin
      int sel = i % 2;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 4 < 2) ? $urandom : 32'($urandom_range(0, 40));
      refAlu(rop, ra, rb, er, ec, eo, ez);
      applyStimulus(sel, rop, ra, rb, r, c, o, z, lat);
      compareAll(sel == 0 ? "rand.step1" : "rand.step4", r, c, o, z, lat,
                 er, ec, eo, ez, refLatency(rop, rb, sel == 0 ? 1 : 4));
    end

    applyStimulus(1, 4'd7, 32'h1, 32'd13, r, c, o, z, lat);
    compareAll("step4.sll13", r, c, o, z, lat, 32'h2000, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus(1, 4'd12, 32'hDEAD, 32'hBEEF, r, c, o, z, lat);
    compareAll("step4.reserved12", r, c, o, z, lat, 32'h0, 1'b0, 1'b0, 1'b1, 1);

    // Backpressure: result must hold while the consumer stalls.
    ra = $urandom; rb = $urandom;
    refAlu(4'd4, ra, rb, er, ec, eo, ez);
    @(negedge clk);
    outReady[0] = 1'b0;
    inValid[0] = 1'b1; opIn[0] = 4'd4; aIn[0] = ra; bIn[0] = rb;
    @(posedge clk);
    @(negedge clk);
    inValid[0] = 1'b0;
    checkOutput("stall.outValid", 64'(outValid[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall.result", 64'(res[0]), 64'(er));
      checkOutput("stall.inReady", 64'(inReady[0]), 64'd0);
      checkOutput("stall.outValid", 64'(outValid[0]), 64'd1);
    end

    seqOp[0] = 4'd0; seqOp[1] = 4'd1; seqOp[2] = 4'd4;
    for (int k = 0; k < 3; k++) begin
      seqA[k] = $urandom; seqB[k] = $urandom;
      refAlu(seqOp[k], seqA[k], seqB[k], seqExp[k], ec, eo, ez);
    end
    outReady[0] = 1'b1;
    inValid[0] = 1'b1; opIn[0] = seqOp[0]; aIn[0] = seqA[0]; bIn[0] = seqB[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("b2b.outValid", 64'(outValid[0]), 64'd1);
      checkOutput("b2b.result", 64'(res[0]), 64'(seqExp[k]));
      if (k < 2) begin
        opIn[0] = seqOp[k+1]; aIn[0] = seqA[k+1]; bIn[0] = seqB[k+1];
      end else begin
        inValid[0] = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("b2b.drained", 64'(outValid[0]), 64'd0);

    // Reset in the middle of a long shift: nothing from it may surface afterwards.
    @(negedge clk);
    inValid[0] = 1'b1; opIn[0] = 4'd7; aIn[0] = 32'h1; bIn[0] = 32'd31;
    @(posedge clk);
    @(negedge clk);
    inValid[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midShift.outValid", 64'(outValid[0]), 64'd0);
    checkOutput("midShift.inReady", 64'(inReady[0]), 64'd0);
    #2 resetN = 1'b0;
    #1;
    checkOutput("rstShift.outValid", 64'(outValid[0]), 64'd0);
    checkOutput("rstShift.result", 64'(res[0]), 64'd0);
    checkOutput("rstShift.zero", 64'(zeroO[0]), 64'd1);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    checkOutput("rstShift.inReady", 64'(inReady[0]), 64'd1);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (outValid[0]) stale++;
    end
    checkOutput("rstShift.noStale", 64'(stale), 64'd0);

    applyStimulus(0, 4'd2, 32'd10, 32'd20, r, c, o, z, lat);
    compareAll("postReset.add", r, c, o, z, lat, 32'd30, 1'b0, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
